clark_sched: RTL

//  Sequencer in front of the Clarke transform: takes raw 12-bit unsigned phase ADC samples,

---
 rtl/foc_pkg.sv | 31 +++
 rtl/clark_sched_if.sv | 53 +++++
 rtl/clark_offset_cal.sv | 71 +++++++
 rtl/clark_sched.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/foc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : foc_pkg
//  Brief   : Shared types, widths and helpers for the clark_sched sequencer.
//  Revision: 1.0  initial release
// ============================================================================
package foc_pkg;

    localparam int ADC_W = 12;
    localparam int CUR_W = 16;
    localparam logic [ADC_W-1:0] OFFSET_RST = 12'd2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAL   = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // 13-bit signed difference, sign-extended and scaled by two.
    function automatic logic signed [CUR_W-1:0] offset_correct(
        input logic [ADC_W-1:0] adc,
        input logic [ADC_W-1:0] off
    );
        logic signed [CUR_W-1:0] diff;
        diff = $signed({{(CUR_W-ADC_W){1'b0}}, adc}) - $signed({{(CUR_W-ADC_W){1'b0}}, off});
        return diff <<< 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clark_sched_if.sv
`default_nettype none
// ============================================================================
//  Module  : clark_sched_if
//  Brief   : ADC, transform-request and result bundle of clark_sched.
//            CLARK_SCHED_DROPCNT_EN adds the o_drop_cnt signal.
//  Revision: 1.0  initial release
// ============================================================================
interface clark_sched_if;
    import foc_pkg::*;

    logic                    i_cal_start;
    logic                    i_adc_en;
    logic [ADC_W-1:0]        i_adc_a;
    logic [ADC_W-1:0]        i_adc_b;
    logic [ADC_W-1:0]        i_adc_c;
    logic                    o_tr_en;
    logic signed [CUR_W-1:0] o_tr_ia;
    logic signed [CUR_W-1:0] o_tr_ib;
    logic signed [CUR_W-1:0] o_tr_ic;
    logic                    i_tr_en;
    logic signed [CUR_W-1:0] i_tr_ialpha;
    logic signed [CUR_W-1:0] i_tr_ibeta;
    logic                    o_en;
    logic signed [CUR_W-1:0] o_ialpha;
    logic signed [CUR_W-1:0] o_ibeta;
    logic                    o_cal_busy;
    logic                    o_timeout;
`ifdef CLARK_SCHED_DROPCNT_EN
    logic [7:0]              o_drop_cnt;
`endif

    modport master (
        output i_cal_start, i_adc_en, i_adc_a, i_adc_b, i_adc_c,
        output i_tr_en, i_tr_ialpha, i_tr_ibeta,
        input  o_tr_en, o_tr_ia, o_tr_ib, o_tr_ic,
        input  o_en, o_ialpha, o_ibeta, o_cal_busy, o_timeout
`ifdef CLARK_SCHED_DROPCNT_EN
        , input o_drop_cnt
`endif
    );

    modport slave (
        input  i_cal_start, i_adc_en, i_adc_a, i_adc_b, i_adc_c,
        input  i_tr_en, i_tr_ialpha, i_tr_ibeta,
        output o_tr_en, o_tr_ia, o_tr_ib, o_tr_ic,
        output o_en, o_ialpha, o_ibeta, o_cal_busy, o_timeout
`ifdef CLARK_SCHED_DROPCNT_EN
        , output o_drop_cnt
`endif
    );

endinterface
`default_nettype wire

// File: rtl/clark_offset_cal.sv
`default_nettype none
// ============================================================================
//  Module  : clark_offset_cal
//  Brief   : Per-phase offset averaging over 2^CAL_LOG2 samples.
//  Revision: 1.0  initial release
// ============================================================================
module clark_offset_cal
    import foc_pkg::*;
#(
    parameter int CAL_LOG2 = 6
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             clear,
    input  wire logic             sample,
    input  wire logic [ADC_W-1:0] adc_a,
    input  wire logic [ADC_W-1:0] adc_b,
    input  wire logic [ADC_W-1:0] adc_c,
    output logic      [ADC_W-1:0] off_a,
    output logic      [ADC_W-1:0] off_b,
    output logic      [ADC_W-1:0] off_c,
    output logic                  final_sample
);

    localparam int SUM_W = ADC_W + CAL_LOG2;

    logic [SUM_W-1:0]    sum_a, sum_b, sum_c;
    logic [SUM_W-1:0]    sum_a_nxt, sum_b_nxt, sum_c_nxt;
    logic [CAL_LOG2-1:0] count;

    // The next accepted sample completes the averaging window.
    assign final_sample = &count;

    assign sum_a_nxt = sum_a + SUM_W'(adc_a);
    assign sum_b_nxt = sum_b + SUM_W'(adc_b);
    assign sum_c_nxt = sum_c + SUM_W'(adc_c);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_a <= '0;
            sum_b <= '0;
            sum_c <= '0;
            count <= '0;
            off_a <= OFFSET_RST;
            off_b <= OFFSET_RST;
            off_c <= OFFSET_RST;
        end else if (clear) begin
            sum_a <= '0;
            sum_b <= '0;
            sum_c <= '0;
            count <= '0;
        end else if (sample) begin
            if (final_sample) begin
                off_a <= sum_a_nxt[SUM_W-1:CAL_LOG2];
                off_b <= sum_b_nxt[SUM_W-1:CAL_LOG2];
                off_c <= sum_c_nxt[SUM_W-1:CAL_LOG2];
                sum_a <= '0;
                sum_b <= '0;
                sum_c <= '0;
                count <= '0;
            end else begin
                sum_a <= sum_a_nxt;
                sum_b <= sum_b_nxt;
                sum_c <= sum_c_nxt;
                count <= count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clark_sched.sv
`default_nettype none
// ============================================================================
//  Module  : clark_sched
//  Brief   : Offset removal, single-flight Clarke request sequencing with
//            timeout. CLARK_SCHED_DROPCNT_EN enables the dropped-sample counter.
//  Revision: 1.0  initial release
// ============================================================================
module clark_sched
    import foc_pkg::*;
#(
    parameter int CAL_LOG2 = 6,
    parameter int TIMEOUT  = 7
) (
    input  wire logic   clk,
    input  wire logic   rstn,
    clark_sched_if.slave bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;

    logic             cal_clear, cal_sample, cal_final;
    logic [ADC_W-1:0] off_a, off_b, off_c;

    logic             tr_load, tr_en_nxt, res_load, timeout_nxt;

    logic                    tr_en, en, cal_busy, timeout;
    logic signed [CUR_W-1:0] tr_ia, tr_ib, tr_ic, ialpha, ibeta;

    clark_offset_cal #(
        .CAL_LOG2 (CAL_LOG2)
    ) u_cal (
        .clk          (clk),
        .rstn         (rstn),
        .clear        (cal_clear),
        .sample       (cal_sample),
        .adc_a        (bus.i_adc_a),
        .adc_b        (bus.i_adc_b),
        .adc_c        (bus.i_adc_c),
        .off_a        (off_a),
        .off_b        (off_b),
        .off_c        (off_c),
        .final_sample (cal_final)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tmo_nxt     = tmo_cnt;
        tr_load     = 1'b0;
        tr_en_nxt   = 1'b0;
        res_load    = 1'b0;
        timeout_nxt = 1'b0;
        cal_clear   = 1'b0;
        cal_sample  = 1'b0;
        // Calibration request overrides everything, including a pending result.
        if (bus.i_cal_start) begin
            cal_clear = 1'b1;
            state_nxt = CAL;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_adc_en) begin
                        tr_load   = 1'b1;
                        tr_en_nxt = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
                CAL: begin
                    if (bus.i_adc_en) begin
                        cal_sample = 1'b1;
                        if (cal_final) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                ISSUE: begin
                    tmo_nxt   = TMO_W'(TIMEOUT);
                    state_nxt = WAIT;
                end
                WAIT: begin
                    if (bus.i_tr_en) begin
                        res_load  = 1'b1;
                        state_nxt = IDLE;
                    end else if (tmo_cnt == TMO_W'(1)) begin
                        tmo_nxt     = '0;
                        timeout_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        tmo_nxt = tmo_cnt - 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tr_en    <= 1'b0;
            tr_ia    <= '0;
            tr_ib    <= '0;
            tr_ic    <= '0;
            en       <= 1'b0;
            ialpha   <= '0;
            ibeta    <= '0;
            timeout  <= 1'b0;
            cal_busy <= 1'b0;
        end else begin
            tr_en    <= tr_en_nxt;
            en       <= res_load;
            timeout  <= timeout_nxt;
            cal_busy <= (state_nxt == CAL);
            if (tr_load) begin
                tr_ia <= offset_correct(bus.i_adc_a, off_a);
                tr_ib <= offset_correct(bus.i_adc_b, off_b);
                tr_ic <= offset_correct(bus.i_adc_c, off_c);
            end
            if (res_load) begin
                ialpha <= bus.i_tr_ialpha;
                ibeta  <= bus.i_tr_ibeta;
            end
        end
    end

`ifdef CLARK_SCHED_DROPCNT_EN
    logic       dropped;
    logic [7:0] drop_cnt;

    assign dropped = bus.i_adc_en && !bus.i_cal_start && ((state == ISSUE) || (state == WAIT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
        end else if (bus.i_cal_start) begin
            drop_cnt <= '0;
        end else if (dropped && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign bus.o_drop_cnt = drop_cnt;
`endif

    assign bus.o_tr_en    = tr_en;
    assign bus.o_tr_ia    = tr_ia;
    assign bus.o_tr_ib    = tr_ib;
    assign bus.o_tr_ic    = tr_ic;
    assign bus.o_en       = en;
    assign bus.o_ialpha   = ialpha;
    assign bus.o_ibeta    = ibeta;
    assign bus.o_cal_busy = cal_busy;
    assign bus.o_timeout  = timeout;

endmodule
`default_nettype wire
